// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU sequencer
package alu_seq_pkg;

  localparam int WIDTH_DEF = 16;

  // 74181 select for A plus B when M=0 and no carry-in is applied
  localparam logic [3:0] ALU_S_ADD = 4'b1001;

  typedef enum logic [1:0] {
    OP_RAW = 2'd0,
    OP_MUL = 2'd1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAW  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle controller for a 74181-style ALU (optional flags: ALU_SEQ_FLAGS_EN)
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MUL_ITERS = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [3:0]           req_s,
  input  logic                 req_m,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_y,
  input  logic                 alu_co,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
`ifdef ALU_SEQ_FLAGS_EN
  output logic                 rsp_zero,
  output logic                 rsp_neg,
`endif
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_carry
);

  localparam int CW = $clog2(MUL_ITERS);

  state_e               state_q, state_d;
  logic [3:0]           s_q, s_d;
  logic                 m_q, m_d;
  logic [WIDTH-1:0]     a_q, a_d;          // RAW operand A / MUL multiplicand
  logic [WIDTH-1:0]     b_q, b_d;          // RAW operand B / MUL low accumulator
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_carry_q, rsp_carry_d;
  // Last values driven onto the ALU, replayed while IDLE or DONE
  logic [3:0]           hold_s_q;
  logic                 hold_m_q;
  logic [WIDTH-1:0]     hold_a_q, hold_b_q;
  logic [3:0]           drv_s;
  logic                 drv_m;
  logic [WIDTH-1:0]     drv_a, drv_b;
`ifdef ALU_SEQ_FLAGS_EN
  logic                 zero_q, zero_d, neg_q, neg_d;
`endif

  // Next-state, datapath update and ALU drive selection
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    m_d         = m_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_hi_d    = acc_hi_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    drv_s       = hold_s_q;
    drv_m       = hold_m_q;
    drv_a       = hold_a_q;
    drv_b       = hold_b_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          s_d      = req_s;
          m_d      = req_m;
          a_d      = req_a;
          b_d      = req_b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = (req_op == OP_MUL) ? ST_MUL : ST_RAW;
        end
      end
      ST_RAW: begin
        drv_s       = s_q;
        drv_m       = m_q;
        drv_a       = a_q;
        drv_b       = b_q;
        rsp_data_d  = {{WIDTH{1'b0}}, alu_y};
        rsp_carry_d = alu_co;
`ifdef ALU_SEQ_FLAGS_EN
        zero_d      = (alu_y == '0);
        neg_d       = alu_y[WIDTH-1];
`endif
        state_d     = ST_DONE;
      end
      ST_MUL: begin
        // Shift-add step: add multiplicand when the current multiplier bit is set
        drv_s    = ALU_S_ADD;
        drv_m    = 1'b0;
        drv_a    = acc_hi_q;
        drv_b    = b_q[0] ? a_q : '0;
        acc_hi_d = {alu_co, alu_y[WIDTH-1:1]};
        b_d      = {alu_y[0], b_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_ITERS - 1)) begin
          rsp_data_d  = {acc_hi_d, b_d};
          rsp_carry_d = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d      = ({acc_hi_d, b_d} == '0);
          neg_d       = acc_hi_d[WIDTH-1];
`endif
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      m_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      hold_s_q    <= '0;
      hold_m_q    <= 1'b0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      m_q         <= m_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_hi_q    <= acc_hi_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      hold_s_q    <= drv_s;
      hold_m_q    <= drv_m;
      hold_a_q    <= drv_a;
      hold_b_q    <= drv_b;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Result flags, captured together with rsp_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign rsp_zero = zero_q;
  assign rsp_neg  = neg_q;
`endif

  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign alu_s     = drv_s;
  assign alu_m     = drv_m;
  assign alu_a     = drv_a;
  assign alu_b     = drv_b;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer with an ALU stub
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [3:0]  req_s = '0;
  logic        req_m = 1'b0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  alu_s;
  logic        alu_m;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        alu_co;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_carry;
`ifdef ALU_SEQ_FLAGS_EN
  logic        rsp_zero, rsp_neg;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_s(req_s), .req_m(req_m), .req_a(req_a), .req_b(req_b),
    .alu_s(alu_s), .alu_m(alu_m), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_co(alu_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
    .rsp_data(rsp_data), .rsp_carry(rsp_carry)
  );

  function automatic logic [16:0] add17(input logic [15:0] x, input logic [15:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Active-high 74181 function table, no carry-in; logic mode gives carry 0
  function automatic logic [16:0] alu_f(input logic [3:0] s, input logic m,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [15:0] y;
    if (m) begin
      case (s)
        4'd0: y = ~a;        4'd1: y = ~(a | b);  4'd2: y = ~a & b;    4'd3: y = 16'h0;
        4'd4: y = ~(a & b);  4'd5: y = ~b;        4'd6: y = a ^ b;     4'd7: y = a & ~b;
        4'd8: y = ~a | b;    4'd9: y = ~(a ^ b);  4'd10: y = b;        4'd11: y = a & b;
        4'd12: y = 16'hFFFF; 4'd13: y = a | ~b;   4'd14: y = a | b;    default: y = a;
      endcase
      return {1'b0, y};
    end
    case (s)
      4'd0:  return add17(a, 16'h0);
      4'd1:  return add17(a | b, 16'h0);
      4'd2:  return add17(a | ~b, 16'h0);
      4'd3:  return add17(16'h0, 16'hFFFF);
      4'd4:  return add17(a, a & ~b);
      4'd5:  return add17(a | b, a & ~b);
      4'd6:  return add17(a, ~b);
      4'd7:  return add17(a & ~b, 16'hFFFF);
      4'd8:  return add17(a, a & b);
      4'd9:  return add17(a, b);
      4'd10: return add17(a | ~b, a & b);
      4'd11: return add17(a & b, 16'hFFFF);
      4'd12: return add17(a, a);
      4'd13: return add17(a | b, a);
      4'd14: return add17(a | ~b, a);
      default: return add17(a, 16'hFFFF);
    endcase
  endfunction

  // ALU stub driven by the sequencer
  always_comb {alu_co, alu_y} = alu_f(alu_s, alu_m, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model: one outstanding request, fixed latency
  bit          m_busy = 1'b0;
  bit          m_mul;
  int          m_wait;
  logic [3:0]  m_s;
  logic        m_m;
  logic [15:0] m_a, m_b;
  logic [31:0] m_data;
  logic        m_carry;

  initial forever begin
    logic [16:0] r;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1;
        m_mul  = (req_op == 2'd1);
        m_s = req_s; m_m = req_m; m_a = req_a; m_b = req_b;
        m_wait = m_mul ? 16 : 1;
        if (m_mul) begin
          m_data  = 32'(req_a) * 32'(req_b);
          m_carry = 1'b0;
        end else begin
          r       = alu_f(req_s, req_m, req_a, req_b);
          m_data  = {16'h0, r[15:0]};
          m_carry = r[16];
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
    end else begin
      chk("req_ready", req_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_busy && m_wait == 0);
      if (m_busy && m_wait == 0) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_carry", rsp_carry, m_carry);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rsp_zero", rsp_zero, m_data == 0);
        chk("rsp_neg", rsp_neg, m_mul ? m_data[31] : m_data[15]);
`endif
      end
      if (m_busy && m_wait > 0) begin
        if (m_mul) begin
          chk("mul_alu_s", alu_s, 4'b1001);
          chk("mul_alu_m", alu_m, 0);
        end else begin
          chk("raw_alu_s", alu_s, m_s);
          chk("raw_alu_m", alu_m, m_m);
          chk("raw_alu_a", alu_a, m_a);
          chk("raw_alu_b", alu_b, m_b);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] s, input logic m,
                      input logic [15:0] a, input logic [15:0] b, input int hold,
                      output logic [31:0] d, output logic c, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 0, 1);
    req_valid = 1'b1; req_op = op; req_s = s; req_m = m; req_a = a; req_b = b;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_s = 4'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    d = rsp_data;
    c = rsp_carry;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_data", rsp_data, d);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_rsp", req_ready, 1);
  endtask

  initial begin
    logic [31:0] d;
    logic        c;
    int          lat;
    int          hs;

    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_alu_a", alu_a, 0);
    #2 rst_n = 1'b1;

    send(2'd0, 4'b1001, 1'b0, 16'h8000, 16'h8000, 0, d, c, lat);
    chk("raw_add_data", d, 32'h0000_0000);
    chk("raw_add_carry", c, 1);
    chk("raw_latency", lat, 1);

    send(2'd1, 4'h0, 1'b0, 16'd3, 16'd5, 0, d, c, lat);
    chk("mul_3x5", d, 32'h0000_000F);
    chk("mul_latency", lat, 16);

    send(2'd1, 4'h0, 1'b0, 16'hFFFF, 16'hFFFF, 0, d, c, lat);
    chk("mul_ffff", d, 32'hFFFE_0001);
    chk("mul_carry", c, 0);

    send(2'd1, 4'h0, 1'b0, 16'h0000, 16'h1234, 0, d, c, lat);
    chk("mul_zero", d, 32'h0);

    send(2'd1, 4'h0, 1'b0, 16'h1234, 16'h5678, 10, d, c, lat);
    chk("mul_hold", d, 32'h0626_0060);

    send(2'd3, 4'd6, 1'b1, 16'hF0F0, 16'hFF00, 0, d, c, lat);
    chk("reserved_op_xor", d, 32'h0000_0FF0);
    chk("reserved_op_latency", lat, 1);

    // Reset in the middle of a multiply
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_a = 16'h1357; req_b = 16'h2468;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_alu_s", alu_s, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_b", alu_b, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_stale_rsp", rsp_valid, 0);
    send(2'd0, 4'd9, 1'b0, 16'h1111, 16'h2222, 0, d, c, lat);
    chk("post_reset_raw", d, 32'h0000_3333);
    chk("post_reset_carry", c, 0);

    // Back-to-back RAW with req_valid and rsp_ready held high
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_s = 4'd9; req_m = 1'b0; rsp_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 30; i++) begin
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      @(negedge clk);
      if (rsp_valid) hs++;
    end
    req_valid = 1'b0;
    chk("b2b_responses", hs, 10);
    repeat (5) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 2'($urandom);
      req_s     = 4'($urandom);
      req_m     = 1'($urandom);
      req_a     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      req_b     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("drain_idle", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that owns the 16-bit 74181-style combinational ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU's S, M, A and B inputs from registered state.
- Single-pass ops take one ALU cycle. Unsigned 16x16 multiply is built from 16 shift-add iterations through the ALU.
- Returns a 32-bit result over a second valid/ready handshake. Sits between the CPU execute stage and the ALU instance.

Parameters:
- WIDTH, 16, datapath width; the only supported value is 16, since MUL_ITERS and result width derive from it.
- MUL_ITERS, 16, number of multiply iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  0=RAW, 1=MUL, 2-3 reserved (treated as RAW)
- req_s  in  4  RAW only: S function select; bit i drives ALU S[i]
- req_m  in  1  RAW only: ALU mode (1=logic, 0=arithmetic)
- req_a  in  16  operand A / multiplicand
- req_b  in  16  operand B / multiplier
- alu_s  out  4  to ALU S
- alu_m  out  1  to ALU M
- alu_a  out  16  to ALU A
- alu_b  out  16  to ALU B
- alu_y  in  16  from ALU result
- alu_co  in  1  from ALU carry out of bit 15
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  result
- rsp_carry  out  1  RAW: captured alu_co; MUL: 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, all outputs and registers 0, req_ready=0 while rst_n low. rsp_valid=0.
- Bit conventions: bit 0 is LSB on every bus; ALU carry propagates bit 0 to bit 15.
- States: IDLE, RAW, MUL, DONE.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready at a rising edge; operands and fields are registered on that edge.
- ALU drive: alu_* are combinational from registered state only, never from req_* directly. In IDLE and DONE, alu_s/alu_m/alu_a/alu_b hold their last values.
- IDLE -> RAW (op 0, 2, 3) or MUL (op 1) on accept.
- RAW, one cycle:
  - alu_s=req_s, alu_m=req_m, alu_a=A, alu_b=B.
  - At the edge: capture rsp_data={16'h0, alu_y}, rsp_carry=alu_co; go to DONE.
- MUL:
  - On accept: mcand=A, acc_hi=0, acc_lo=B, cnt=0.
  - Each MUL cycle drives alu_s=ALU_S_ADD, alu_m=0, alu_a=acc_hi, alu_b=acc_lo[0] ? mcand : 0.
  - At each edge: acc_hi <= {alu_co, alu_y[15:1]}; acc_lo <= {alu_y[0], acc_lo[15:1]}; cnt++.
  - After the 16th iteration (cnt==15 at the edge): rsp_data={acc_hi,acc_lo} as post-update values; rsp_carry=0; go to DONE.
- DONE: rsp_valid=1, and rsp_data/rsp_carry are stable until the handshake. On rsp_valid & rsp_ready, go to IDLE.
- Latency from accept edge to rsp_valid high: RAW 1 cycle, MUL 16 cycles. Minimum throughput is one request every latency+2 cycles, with no overlap.
- Boundary conditions:
  - rsp_ready held low: the sequencer waits in DONE indefinitely and req_ready stays 0.
  - rsp_ready high on entry to DONE: rsp_valid is still visible for at least one cycle.
  - Reset mid-operation: the operation is aborted with no response.
  - req_* changing after accept: no effect.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- When defined: extra outputs rsp_zero (rsp_data==0) and rsp_neg (RAW: rsp_data[15]; MUL: rsp_data[31]). Both are registered with rsp_data and reset to 0.
- When undefined: the ports are absent and there is no flag logic.

Decomposition:
- Package alu_seq_pkg:
  - op enum values OP_RAW=2'd0, OP_MUL=2'd1;
  - state enum values;
  - constant ALU_S_ADD=4'b1001 with M=0 (A plus B, no carry-in);
  - WIDTH default.
- No sub-module; the MUL datapath is inline. The ALU is instantiated by the parent, not inside this block.

Test Plan:
- RAW, S=ALU_S_ADD, M=0, A=16'h8000, B=16'h8000 -> rsp_data=32'h0000_0000, rsp_carry=1, rsp_valid exactly 1 cycle after accept.
- MUL A=3, B=5 -> rsp_data=32'h0000_000F after 16 cycles; alu_s=ALU_S_ADD, alu_m=0 every MUL cycle.
- MUL A=16'hFFFF, B=16'hFFFF -> rsp_data=32'hFFFE_0001; MUL A=0, B=16'h1234 -> 0.
- rsp_ready held low 10 cycles after MUL completes -> rsp_data stable, req_ready=0 throughout; accept on release, IDLE next cycle.
- rst_n asserted at MUL iteration 7 -> all outputs 0 immediately; after release, a new RAW request completes correctly with no stale response.
- Back-to-back requests with req_valid held high -> second request accepted on the first cycle back in IDLE; results in order.
